h264dcquantise: RTL and testbench

Chroma DC quantiser: takes the four 2x2 Hadamard-transformed chroma DC coefficients streamed out of the DC transform stage and quantises each one with the H.264 chroma-DC rule. Emits four signed 12-bit levels per group in arrival order, plus a last-of-group marker and a group nonzero flag. The levels go to the reorder/CAVLC stage. It is a 3-stage pipeline with full backpressure.

---
 rtl/h264dcquantise.sv | 143 ++++++++++++++
 tb/tb_h264dcquantise.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/h264dcquantise.sv
// H.264 chroma DC quantiser: four Hadamard DC coefficients per group in, four
// signed 12-bit levels out, with last-of-group and group-nonzero markers.
module h264dcquantise (
  input  logic        CLK,
  input  logic        RESET,
  output logic        READYI,
  input  logic        ENABLE,
  input  logic [15:0] YYIN,
  input  logic [5:0]  QP,
  input  logic        INTRA,
  output logic        VALID,
  output logic [11:0] ZOUT,
  output logic        LAST,
  output logic        NZ,
  input  logic        READYO
);

  logic        w_adv, w_acc;
  logic [5:0]  w_qpc, w_qp, w_mod;
  logic        w_intra;
  logic [3:0]  w_div;
  logic [13:0] w_mf;
  logic [22:0] w_r3;
  logic [16:0] w_mag;
  logic [31:0] w_sum, w_q;
  logic [10:0] w_m3;
  logic        w_nz;

  logic [1:0]  r_idx;
  logic [5:0]  r_gqp;
  logic        r_gintra;
  logic        r_v1, r_sgn1, r_last1;
  logic [16:0] r_mag1;
  logic [13:0] r_mf1;
  logic [4:0]  r_s1;
  logic [22:0] r_r1;
  logic        r_v2, r_sgn2, r_last2;
  logic [30:0] r_p2;
  logic [4:0]  r_s2;
  logic [22:0] r_r2;
  logic        r_v3, r_sgn3, r_last3;
  logic [10:0] r_mag3;
  logic        r_nzacc;

  assign w_adv  = !VALID || READYO;
  assign READYI = w_adv;
  assign w_acc  = ENABLE && w_adv;

  // Coefficient 0 uses the live QP/INTRA; later ones use the latched group copy.
  assign w_qpc   = (QP > 6'd51) ? 6'd51 : QP;
  assign w_qp    = (r_idx == 2'd0) ? w_qpc : r_gqp;
  assign w_intra = (r_idx == 2'd0) ? INTRA : r_gintra;

  // qp/6 via multiply-by-43 >> 8, exact over 0..51.
  assign w_div = 4'(({6'd0, w_qp} * 12'd43) >> 8);
  assign w_mod = w_qp - 6'({w_div, 2'b00}) - 6'({w_div, 1'b0});

  always_comb begin
    w_mf = 14'd13107;
    case (w_mod)
      6'd1:    w_mf = 14'd11916;
      6'd2:    w_mf = 14'd10082;
      6'd3:    w_mf = 14'd9362;
      6'd4:    w_mf = 14'd8192;
      6'd5:    w_mf = 14'd7282;
      default: w_mf = 14'd13107;
    endcase
  end

  // floor(2^s/3) for s = 16 + qp/6; the inter term floor(2^s/6) is this halved.
  always_comb begin
    w_r3 = 23'd21845;
    case (w_div)
      4'd1:    w_r3 = 23'd43690;
      4'd2:    w_r3 = 23'd87381;
      4'd3:    w_r3 = 23'd174762;
      4'd4:    w_r3 = 23'd349525;
      4'd5:    w_r3 = 23'd699050;
      4'd6:    w_r3 = 23'd1398101;
      4'd7:    w_r3 = 23'd2796202;
      4'd8:    w_r3 = 23'd5592405;
      default: w_r3 = 23'd21845;
    endcase
  end

  assign w_mag = YYIN[15] ? (17'd0 - {1'b1, YYIN}) : {1'b0, YYIN};
  assign w_sum = {1'b0, r_p2} + {9'd0, r_r2};
  assign w_q   = w_sum >> r_s2;
  assign w_m3  = (w_q > 32'd2047) ? 11'd2047 : w_q[10:0];
  assign w_nz  = r_nzacc || (r_mag3 != 11'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_idx <= '0; r_gqp <= '0; r_gintra <= 1'b0;
      r_v1 <= 1'b0; r_sgn1 <= 1'b0; r_last1 <= 1'b0; r_mag1 <= '0;
      r_mf1 <= '0; r_s1 <= '0; r_r1 <= '0;
      r_v2 <= 1'b0; r_sgn2 <= 1'b0; r_last2 <= 1'b0; r_p2 <= '0;
      r_s2 <= '0; r_r2 <= '0;
      r_v3 <= 1'b0; r_sgn3 <= 1'b0; r_last3 <= 1'b0; r_mag3 <= '0;
      r_nzacc <= 1'b0;
      VALID <= 1'b0; ZOUT <= '0; LAST <= 1'b0; NZ <= 1'b0;
    end else if (w_adv) begin
      if (w_acc) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd0) begin
          r_gqp    <= w_qpc;
          r_gintra <= INTRA;
        end
      end
      r_v1    <= w_acc;
      r_sgn1  <= YYIN[15];
      r_mag1  <= w_mag;
      r_mf1   <= w_mf;
      r_s1    <= 5'd16 + {1'b0, w_div};
      r_r1    <= w_intra ? w_r3 : (w_r3 >> 1);
      r_last1 <= (r_idx == 2'd3);

      r_v2    <= r_v1;
      r_sgn2  <= r_sgn1;
      r_p2    <= 31'(r_mag1) * 31'(r_mf1);
      r_s2    <= r_s1;
      r_r2    <= r_r1;
      r_last2 <= r_last1;

      r_v3    <= r_v2;
      r_sgn3  <= r_sgn2;
      r_mag3  <= w_m3;
      r_last3 <= r_last2;

      VALID <= r_v3;
      ZOUT  <= (r_sgn3 && r_mag3 != 11'd0) ? (12'd0 - {1'b0, r_mag3}) : {1'b0, r_mag3};
      if (r_v3) begin
        LAST    <= r_last3;
        NZ      <= r_last3 && w_nz;
        r_nzacc <= r_last3 ? 1'b0 : w_nz;
      end else begin
        LAST <= 1'b0;
        NZ   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_h264dcquantise.sv
// Directed bench for h264dcquantise: hand-computed levels, scoreboarded output.
module tb_h264dcquantise;
  logic        CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b0, INTRA = 1'b0, READYO = 1'b1;
  logic [15:0] YYIN = '0;
  logic [5:0]  QP = '0;
  logic        READYI, VALID, LAST, NZ;
  logic [11:0] ZOUT;

  h264dcquantise dut (
    .CLK(CLK), .RESET(RESET), .READYI(READYI), .ENABLE(ENABLE), .YYIN(YYIN),
    .QP(QP), .INTRA(INTRA), .VALID(VALID), .ZOUT(ZOUT), .LAST(LAST), .NZ(NZ),
    .READYO(READYO)
  );

  always #5 CLK = ~CLK;

  typedef struct { int z; bit last; bit nz; } exp_t;
  exp_t expq[$];
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transfer must match the next queued level in order.
  always @(negedge CLK) begin
    if (mon_en && VALID && READYO) begin
      if (expq.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = expq.pop_front();
        chk("zout", int'($signed(ZOUT)), e.z);
        chk("last", int'(LAST), int'(e.last));
        if (e.last) chk("nz", int'(NZ), int'(e.nz));
      end
    end
  end

  task automatic send(input int w, input int qp, input bit intra);
    bit acc;
    int n;
    ENABLE = 1'b1; YYIN = 16'(w); QP = 6'(qp); INTRA = intra;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge CLK); acc = READYI;
      @(posedge CLK); #1; n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic grp(input int qp, input bit intra, input int w0, input int w1,
                     input int w2, input int w3, input int e0, input int e1,
                     input int e2, input int e3);
    bit nz;
    nz = (e0 != 0) || (e1 != 0) || (e2 != 0) || (e3 != 0);
    expq.push_back('{e0, 1'b0, 1'b0});
    expq.push_back('{e1, 1'b0, 1'b0});
    expq.push_back('{e2, 1'b0, 1'b0});
    expq.push_back('{e3, 1'b1, nz});
    send(w0, qp, intra);
    send(w1, 0, 1'b0);   // later coefficients must ignore these QP/INTRA values
    send(w2, 0, 1'b0);
    send(w3, 0, 1'b0);
  endtask

  task automatic drain();
    int n;
    ENABLE = 1'b0;
    n = 0;
    while (expq.size() > 0 && n < 200) begin @(posedge CLK); n++; end
    chk("drain_empty", expq.size(), 0);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w[4];
    int e[4];
    logic [11:0] z0;
    w = '{100, -100, 0, 0};
    e = '{20, -20, 0, 0};

    repeat (3) @(posedge CLK);
    #1; RESET = 1'b0;
    chk("rst_readyi", int'(READYI), 1);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_zout", int'(ZOUT), 0);
    chk("rst_last", int'(LAST), 0);
    chk("rst_nz", int'(NZ), 0);

    // Latency: coefficient accepted at edge k is visible after edge k+3.
    for (int i = 0; i < 4; i++) begin
      ENABLE = 1'b1; YYIN = 16'(w[i]); QP = 6'd0; INTRA = 1'b1;
      @(posedge CLK); #1;
      if (i < 3) chk("lat_valid_low", int'(VALID), 0);
    end
    ENABLE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lat_valid", int'(VALID), 1);
      chk("lat_zout", int'($signed(ZOUT)), e[i]);
      chk("lat_last", int'(LAST), (i == 3) ? 1 : 0);
      if (i == 3) chk("lat_nz", int'(NZ), 1);
      @(posedge CLK); #1;
    end
    chk("lat_idle", int'(VALID), 0);

    mon_en = 1'b1;
    grp(28, 1'b1, 1000, 1000, -1000, 0, 8, 8, -8, 0);
    grp(0, 1'b1, 4, 32767, -32768, 0, 1, 2047, -2047, 0);
    grp(0, 1'b0, 4, 4, 4, 4, 0, 0, 0, 0);
    grp(0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    grp(0, 1'b1, 0, 0, 0, 5, 0, 0, 0, 1);
    grp(63, 1'b1, 32767, -32767, 0, 0, 18, -18, 0, 0);
    drain();

    // Three back-to-back groups with a 5-cycle downstream stall mid-stream.
    fork
      begin
        grp(0, 1'b1, 100, -100, 4, -4, 20, -20, 1, -1);
        grp(28, 1'b1, 1000, 2000, -3000, 0, 8, 15, -23, 0);
        grp(0, 1'b0, 4, 100, 0, 32767, 0, 20, 0, 2047);
        ENABLE = 1'b0;
      end
      begin
        repeat (6) @(posedge CLK);
        #1; READYO = 1'b0;
        @(negedge CLK);
        chk("stall_valid", int'(VALID), 1);
        z0 = ZOUT;
        repeat (5) begin
          chk("stall_readyi", int'(READYI), 0);
          chk("stall_frozen", int'(ZOUT), int'(z0));
          @(negedge CLK);
        end
        @(posedge CLK); #1; READYO = 1'b1;
      end
    join
    drain();

    // Reset after two coefficients: the pair vanishes, idx restarts at 0.
    send(100, 0, 1'b1);
    send(100, 0, 1'b1);
    ENABLE = 1'b0; RESET = 1'b1;
    @(posedge CLK); #1; RESET = 1'b0;
    chk("rst_mid_valid", int'(VALID), 0);
    grp(0, 1'b1, 4, 100, -4, 0, 1, 20, -1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
